// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler that pops four source FIFOs and forwards each word
// to one of two destination FIFOs, two cycles after the pop.
module fifo_rr_scheduler #(
  parameter int DATA_SIZE = 12,
  parameter int NUM_SRC   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_SRC-1:0]            fifo_empty,
  input  logic [NUM_SRC*DATA_SIZE-1:0]  fifo_data_out,
  input  logic [1:0]                    dest_almost_full,
  output logic [NUM_SRC-1:0]            fifo_pop,
  output logic [1:0]                    dest_push,
  output logic [DATA_SIZE-1:0]          data_out,
  output logic [1:0]                    grant_idx,
  output logic                          idle,
  output logic [7:0]                    words_fwd
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t       state, state_next;
  logic [1:0]   ptr;
  logic         rd_valid;
  logic [1:0]   rd_idx;
  logic [NUM_SRC-1:0] eligible;
  logic         grant_valid;
  logic [1:0]   grant;
  logic [1:0]   scan_idx;
  logic [1:0]   in_flight;

  // A source popped last cycle is masked so its FIFO has time to update empty.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = enable && !fifo_empty[i] && !dest_almost_full[i/2] && !fifo_pop[i];
    end
  end

  // NOTE: every variable gets a default before any conditional write so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant       = ptr;
    scan_idx    = ptr;
    for (int off = 0; off < NUM_SRC; off++) begin
      scan_idx = ptr + 2'(off);
      if (!grant_valid && eligible[scan_idx]) begin
        grant_valid = 1'b1;
        grant       = scan_idx;
      end
    end
  end

  // Words in flight: one being popped now plus one whose read data is valid now.
  assign in_flight = {1'b0, |fifo_pop} + {1'b0, rd_valid};

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_valid) state_next = RUN;
      RUN: begin
        if (!enable && in_flight != 2'd0)          state_next = DRAIN;
        else if (!grant_valid && in_flight == 2'd0) state_next = IDLE;
      end
      DRAIN: begin
        if (grant_valid)             state_next = RUN;
        else if (in_flight == 2'd0)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      fifo_pop  <= '0;
      grant_idx <= '0;
      rd_valid  <= 1'b0;
      rd_idx    <= '0;
      dest_push <= '0;
      data_out  <= '0;
      words_fwd <= '0;
    end else begin
      state    <= state_next;
      fifo_pop <= grant_valid ? (NUM_SRC'(1) << grant) : '0;
      if (grant_valid) begin
        grant_idx <= grant;
        ptr       <= grant + 2'd1;
      end
      rd_valid  <= |fifo_pop;
      rd_idx    <= grant_idx;
      dest_push <= '0;
      if (rd_valid) begin
        dest_push <= 2'b01 << rd_idx[1];
        data_out  <= fifo_data_out[rd_idx*DATA_SIZE +: DATA_SIZE];
        words_fwd <= words_fwd + 8'd1;
      end
    end
  end

  assign idle = (state == IDLE);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: queue-based source FIFOs, a transaction-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_fifo_rr_scheduler;
  localparam int DS = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [3:0]    fifo_empty;
  logic [4*DS-1:0] fifo_data_out;
  logic [1:0]    dest_almost_full;
  logic [3:0]    fifo_pop;
  logic [1:0]    dest_push;
  logic [DS-1:0] data_out;
  logic [1:0]    grant_idx;
  logic          idle;
  logic [7:0]    words_fwd;

  fifo_rr_scheduler #(.DATA_SIZE(DS), .NUM_SRC(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .dest_almost_full(dest_almost_full),
    .fifo_pop(fifo_pop), .dest_push(dest_push), .data_out(data_out),
    .grant_idx(grant_idx), .idle(idle), .words_fwd(words_fwd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source FIFOs: word becomes visible on fifo_data_out one cycle after its pop.
  logic [DS-1:0] mem [4][512];
  int            wr_ptr [4] = '{default: 0};
  int            rd_ptr [4] = '{default: 0};
  logic [DS-1:0] rd_word [4] = '{default: '0};
  logic [3:0]    pop_seen = '0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (rd_ptr[i] >= wr_ptr[i]);
      fifo_data_out[i*DS +: DS] = rd_word[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop_seen[i] && rd_ptr[i] < wr_ptr[i]) begin
        rd_word[i] <= mem[i][rd_ptr[i]];
        rd_ptr[i]  <= rd_ptr[i] + 1;
      end
    end
  end

  task automatic load(input int s, input logic [DS-1:0] w);
    mem[s][wr_ptr[s]] = w;
    wr_ptr[s] = wr_ptr[s] + 1;
  endtask

  // Reference model: a round-robin arbiter over eligible sources and a list
  // of words scheduled to appear at the destinations two edges after the pop.
  typedef struct { int due; int dest; logic [DS-1:0] data; } ev_t;
  typedef enum { M_IDLE, M_RUN, M_DRAIN } mstate_t;

  ev_t           pend[$];
  ev_t           ev;
  mstate_t       m_state = M_IDLE;
  int            m_ptr = 0;
  int            m_last = -1;
  int            m_cnt [4] = '{default: 0};
  int            cyc = 0;
  bit            started = 1'b0;
  logic [3:0]    e_pop = '0;
  logic [1:0]    e_push = '0;
  logic [DS-1:0] e_data = '0;
  logic [1:0]    e_gidx = '0;
  logic [7:0]    e_fwd = '0;
  logic          e_idle = 1'b1;

  always @(posedge clk) begin
    int grant;
    int words;
    cyc++;
    started = 1'b1;
    if (reset) begin
      pend.delete();
      m_state = M_IDLE; m_ptr = 0; m_last = -1;
      e_pop = '0; e_push = '0; e_data = '0; e_gidx = '0; e_fwd = '0; e_idle = 1'b1;
    end else begin
      words = pend.size();
      grant = -1;
      for (int off = 0; off < 4; off++) begin
        int j;
        j = (m_ptr + off) % 4;
        if (grant < 0 && enable && !fifo_empty[j] && !dest_almost_full[j/2] && m_last != j)
          grant = j;
      end
      e_push = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        ev = pend.pop_front();
        e_push = 2'(1 << ev.dest);
        e_data = ev.data;
        e_fwd  = e_fwd + 8'd1;
      end
      e_pop = '0;
      if (grant >= 0) begin
        ev.due  = cyc + 2;
        ev.dest = grant / 2;
        ev.data = mem[grant][m_cnt[grant]];
        pend.push_back(ev);
        m_cnt[grant]++;
        e_pop  = 4'(1 << grant);
        e_gidx = 2'(grant);
        m_ptr  = (grant + 1) % 4;
      end
      m_last = grant;
      case (m_state)
        M_IDLE:  if (grant >= 0) m_state = M_RUN;
        M_RUN:   if (!enable && words > 0) m_state = M_DRAIN;
                 else if (grant < 0 && words == 0) m_state = M_IDLE;
        default: if (grant >= 0) m_state = M_RUN;
                 else if (words == 0) m_state = M_IDLE;
      endcase
      e_idle = (m_state == M_IDLE);
    end
  end

  // Per-cycle comparison and activity logs used by the directed scenarios.
  int            ncyc = 0;
  int            pop_src[$], pop_cyc[$], push_val[$], push_cyc[$];
  logic [DS-1:0] push_data[$];

  always @(negedge clk) begin
    ncyc++;
    pop_seen = fifo_pop;
    if (started) begin
      check("fifo_pop", fifo_pop, e_pop);
      check("dest_push", dest_push, e_push);
      check("data_out", data_out, e_data);
      check("words_fwd", words_fwd, e_fwd);
      check("idle", idle, e_idle);
      if (fifo_pop != 0) check("grant_idx", grant_idx, e_gidx);
      for (int i = 0; i < 4; i++) begin
        if (fifo_pop[i]) begin
          pop_src.push_back(i);
          pop_cyc.push_back(ncyc);
        end
      end
      if (dest_push != 0) begin
        push_val.push_back(int'(dest_push));
        push_data.push_back(data_out);
        push_cyc.push_back(ncyc);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_src.delete(); pop_cyc.delete();
    push_val.delete(); push_data.delete(); push_cyc.delete();
  endtask

  function automatic int count_src(input int lo, input int hi);
    int c = 0;
    foreach (pop_src[k]) if (pop_src[k] >= lo && pop_src[k] <= hi) c++;
    return c;
  endfunction

  initial begin
    int exp_src[5];
    int exp_push[5];
    logic [DS-1:0] exp_data[5];

    reset = 1'b1; enable = 1'b0; dest_almost_full = 2'b00;
    run(3);
    check("rst_fifo_pop", fifo_pop, 0);
    check("rst_dest_push", dest_push, 0);
    check("rst_data_out", data_out, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_words_fwd", words_fwd, 0);
    check("rst_idle", idle, 1);
    reset = 1'b0;
    run(2);

    // All four sources loaded: strict rotation, pushes two cycles later.
    clear_logs();
    for (int s = 0; s < 4; s++)
      for (int n = 0; n < 2; n++) load(s, DS'((s << 8) | (16 + n)));
    enable = 1'b1;
    run(14);
    exp_src  = '{0, 1, 2, 3, 0};
    exp_push = '{1, 1, 2, 2, 1};
    exp_data = '{12'h010, 12'h110, 12'h210, 12'h310, 12'h011};
    check("rot_pop_count", pop_src.size(), 8);
    check("rot_push_count", push_val.size(), 8);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rot_pop_src%0d", k), pop_src[k], exp_src[k]);
      check($sformatf("rot_push_dest%0d", k), push_val[k], exp_push[k]);
      check($sformatf("rot_push_data%0d", k), push_data[k], exp_data[k]);
    end
    check("rot_latency", push_cyc[0] - pop_cyc[0], 2);
    check("rot_back_to_back", pop_cyc[4] - pop_cyc[0], 4);
    check("rot_idle_after", idle, 1);

    // Single source: the repeat mask spaces its pops two cycles apart.
    clear_logs();
    load(2, 12'h04A); load(2, 12'h05A);
    run(10);
    check("one_pop_count", pop_src.size(), 2);
    check("one_pop_src0", pop_src[0], 2);
    check("one_pop_src1", pop_src[1], 2);
    check("one_pop_gap", pop_cyc[1] - pop_cyc[0], 2);
    check("one_push_count", push_val.size(), 2);
    check("one_push_dest0", push_val[0], 2);
    check("one_push_dest1", push_val[1], 2);
    check("one_push_data0", push_data[0], 12'h04A);
    check("one_push_data1", push_data[1], 12'h05A);

    // Backpressure: both destinations full, then only dest 0 full, then none.
    dest_almost_full = 2'b11;
    clear_logs();
    for (int s = 0; s < 4; s++)
      for (int n = 0; n < 3; n++) load(s, DS'((s << 8) | (48 + n)));
    run(5);
    check("af11_pop_count", pop_src.size(), 0);
    check("af11_idle", idle, 1);
    dest_almost_full = 2'b01;
    clear_logs();
    run(12);
    check("af01_pop_count", pop_src.size(), 6);
    check("af01_only_2_3", count_src(2, 3), 6);
    dest_almost_full = 2'b00;
    clear_logs();
    run(14);
    check("af00_pop_count", pop_src.size(), 6);
    check("af00_src0", count_src(0, 0), 3);
    check("af00_src1", count_src(1, 1), 3);

    // Enable dropped with two words in flight: both complete, no new pops.
    clear_logs();
    load(0, 12'h0A1); load(1, 12'h1A1); load(2, 12'h2A1);
    run(2);
    check("drain_two_popped", pop_src.size(), 2);
    enable = 1'b0;
    clear_logs();
    run(1);
    check("drain_not_idle", idle, 0);
    check("drain_no_pop", fifo_pop, 0);
    run(6);
    check("drain_push_count", push_val.size(), 2);
    check("drain_pop_count", pop_src.size(), 0);
    check("drain_idle", idle, 1);
    enable = 1'b1;
    run(8);

    // Reset with two words in flight: everything cleared, nothing pushed.
    clear_logs();
    load(0, 12'h0B1); load(1, 12'h1B1);
    run(2);
    check("rst2_two_popped", pop_src.size(), 2);
    clear_logs();
    reset = 1'b1;
    run(1);
    check("rst2_fifo_pop", fifo_pop, 0);
    check("rst2_dest_push", dest_push, 0);
    check("rst2_data_out", data_out, 0);
    check("rst2_grant_idx", grant_idx, 0);
    check("rst2_words_fwd", words_fwd, 0);
    check("rst2_idle", idle, 1);
    reset = 1'b0;
    enable = 1'b0;
    run(4);
    check("rst2_no_push", push_val.size(), 0);
    check("rst2_fwd_zero", words_fwd, 0);

    // 256 forwarded words wrap the counter back to zero.
    enable = 1'b1;
    clear_logs();
    for (int s = 0; s < 4; s++)
      for (int n = 0; n < 64; n++) load(s, DS'((s << 8) | (128 + n)));
    run(272);
    check("wrap_pop_count", pop_src.size(), 256);
    check("wrap_push_count", push_val.size(), 256);
    check("wrap_words_fwd", words_fwd, 0);
    check("wrap_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 12, meaning word width of every source/destination FIFO.
REQ-002 SHALL have parameter NUM_SRC, fixed at 4, meaning number of source FIFOs served.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, permits new pops when high.
REQ-006 SHALL have port fifo_empty, input, 4, empty flag of source FIFO i on bit i.
REQ-007 SHALL have port fifo_data_out, input, 4*DATA_SIZE, source i word at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-008 SHALL have port dest_almost_full, input, 2, almost_full of destination FIFO 0/1.
REQ-009 SHALL have port fifo_pop, output, 4, registered one-hot read strobe to source FIFOs.
REQ-010 SHALL have port dest_push, output, 2, registered one-hot write strobe to destination FIFOs.
REQ-011 SHALL have port data_out, output, DATA_SIZE, registered word driven with dest_push.
REQ-012 SHALL have port grant_idx, output, 2, index of source popped in the current cycle (valid when fifo_pop != 0).
REQ-013 SHALL have port idle, output, 1, high when state is IDLE.
REQ-014 SHALL have port words_fwd, output, 8, count of dest_push pulses.

Function
REQ-015 SHALL route sources 0,1 to destination 0 and sources 2,3 to destination 1.
REQ-016 SHALL treat source i eligible at an edge when enable=1, fifo_empty[i]=0, dest_almost_full[i>>1]=0, and i was not granted in the immediately preceding cycle.
REQ-017 SHALL grant the first eligible source searching circularly from round-robin pointer ptr; ptr <= (grant+1) mod 4 on grant, unchanged otherwise.
REQ-018 SHALL assert at most one fifo_pop bit per cycle, for exactly one cycle per grant; back-to-back grants to different sources allowed.
REQ-019 SHALL capture fifo_data_out of the granted source at the end of the cycle following the fifo_pop cycle (source FIFO read data valid one cycle after pop).
REQ-020 SHALL assert dest_push[grant>>1] with data_out in the cycle after capture: push appears exactly 2 cycles after the corresponding pop; up to 2 words in flight.
REQ-021 SHALL never pop a source whose fifo_empty=1 and never push when no word is in flight.
REQ-022 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on a grant; RUN->DRAIN when enable=0 with words in flight; RUN->IDLE when no grant and no words in flight; DRAIN->IDLE when in-flight count reaches 0; DRAIN->RUN if enable returns high and a source is eligible.
REQ-023 SHALL issue no pops in DRAIN while still completing in-flight pushes.
REQ-024 SHALL increment words_fwd by 1 per dest_push pulse, wrapping 255->0.
REQ-025 SHALL hold ptr, fifo_pop=0 when no source is eligible (all empty or both destinations almost_full).

Reset
REQ-026 SHALL, on reset sampled high, set fifo_pop=0, dest_push=0, data_out=0, grant_idx=0, words_fwd=0, ptr=0, state=IDLE, idle=1.
REQ-027 SHALL discard in-flight words when reset asserts mid-operation; no dest_push in the cycle after reset.

Verification
REQ-028 SHALL verify: all four sources non-empty, enable=1 -> pops in order 0,1,2,3,0 on consecutive cycles; pushes 2 cycles later to dest 0,0,1,1,0 with matching data.
REQ-029 SHALL verify: only source 2 non-empty holding 'h4A,'h5A -> pop every other cycle (consecutive-grant mask), pushes of 'h4A then 'h5A on dest_push=2'b10.
REQ-030 SHALL verify: dest_almost_full=2'b01, all sources non-empty -> only sources 2,3 popped; deassert -> sources 0,1 resume.
REQ-031 SHALL verify: enable dropped right after a pop -> state DRAIN, remaining 2 in-flight words pushed, then idle=1, no further pops.
REQ-032 SHALL verify: reset asserted with 2 words in flight -> outputs per REQ-026 next cycle, zero pushes, words_fwd=0.
REQ-033 SHALL verify: 256 forwarded words -> words_fwd wraps to 0.
